// File: rtl/timer_pkg.sv
// Register map, CTRL bit layout and FSM state type shared by the timer_dev RTL and its bench.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_dev_if.sv
// Word-addressed register bus between the system bridge and timer_dev, plus its interrupt line.
interface timer_dev_if #(
  parameter int W = 32
);
  logic [1:0]   addr;
  logic         we;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);

endinterface

// File: rtl/timer_dev.sv
// Programmable down-counter timer on the system bridge; one-shot or auto-reload, with a maskable
// interrupt line toward CP0 ext_int.
module timer_dev
  import timer_pkg::*;
#(
  parameter int           W          = 32,
  parameter logic [W-1:0] PRESET_RST = '0
) (
  input  logic        clk,
  input  logic        rst,
  timer_dev_if.slave  bus
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [W-1:0]      r_preset;
  logic [W-1:0]      r_count;
  logic              r_pend;
  state_t            r_state;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_abort;
  logic w_reload;
  logic w_fire_oneshot;

  assign w_wr_ctrl      = bus.we && (bus.addr == ADDR_CTRL);
  assign w_wr_preset    = bus.we && (bus.addr == ADDR_PRESET);
  assign w_abort        = w_wr_ctrl && !bus.wdata[CTRL_EN];
  assign w_reload       = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign w_fire_oneshot = (r_state == INT) && !w_reload;

  // NOTE: all state below is updated with <= so every branch sees the pre-edge values,
  // which is what lets the bus write and the FSM update the same register in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl   <= '0;
      r_preset <= PRESET_RST;
      r_count  <= '0;
      r_pend   <= 1'b0;
      r_state  <= IDLE;
    end else begin
      if (w_fire_oneshot)
        r_pend <= 1'b1;
      else if (w_wr_ctrl || w_wr_preset)
        r_pend <= 1'b0;

      if (w_wr_preset)
        r_preset <= bus.wdata;

      // A bus write to CTRL overrides the FSM's own EN clear.
      if (w_wr_ctrl)
        r_ctrl <= bus.wdata[CTRL_W-1:0];
      else if (w_fire_oneshot)
        r_ctrl[CTRL_EN] <= 1'b0;

      if (w_abort) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (r_ctrl[CTRL_EN]) r_state <= LOAD;
          LOAD: begin
            r_count <= r_preset;
            r_state <= CNT;
          end
          CNT: begin
            if (!r_ctrl[CTRL_EN]) begin
              r_state <= IDLE;
            end else begin
              if (r_count != '0) r_count <= r_count - W'(1);
              // Leaving at COUNT<=1 also makes PRESET=0 behave like PRESET=1.
              if (r_count <= W'(1)) r_state <= INT;
            end
          end
          INT: r_state <= w_reload ? LOAD : IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: rdata gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_CTRL:   bus.rdata = W'(r_ctrl);
      ADDR_PRESET: bus.rdata = r_preset;
      ADDR_COUNT:  bus.rdata = r_count;
      default:     bus.rdata = '0;
    endcase
  end

  // pend is never set in auto-reload, so the INT term alone gives the per-period pulse there;
  // in one-shot the INT term makes the level start with the terminal count.
  assign bus.irq = r_ctrl[CTRL_IM] && (r_pend || (r_state == INT));

endmodule
